// File: rtl/timer_tick_gen.sv
// Tick generator for a 16-bit timer/counter. It produces one-cycle increment strobes
// from a prescaled clock (timer mode) or from falling edges on a synchronised pin (counter mode).
module timer_tick_gen #(
  parameter int unsigned PRESCALE    = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic gate,
  input  logic intx,
  input  logic tr,
  input  logic cin,
  input  logic c_t,
  output logic cnt_en,
  output logic run
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [SYNC_STAGES-1:0] cin_sync_q, cin_sync_d;
  logic [SYNC_STAGES-1:0] intx_sync_q, intx_sync_d;
  logic                   cin_d_q, cin_d_d;
  logic                   c_t_q, c_t_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   run_q, run_d;
  logic                   cnt_en_q, cnt_en_d;

  logic cin_s;
  logic intx_s;
  logic fall;
  logic mode_chg;
  logic tick;

  assign cin_s    = cin_sync_q[SYNC_STAGES-1];
  assign intx_s   = intx_sync_q[SYNC_STAGES-1];
  assign fall     = cin_d_q & ~cin_s;
  assign mode_chg = c_t ^ c_t_q;

  always_comb begin
    cin_sync_d  = {cin_sync_q[SYNC_STAGES-2:0], cin};
    intx_sync_d = {intx_sync_q[SYNC_STAGES-2:0], intx};
    cin_d_d     = cin_s;
    c_t_d       = c_t;
    run_d       = tr & (~gate | intx_s);
  end

  // The prescaler advances on the registered run so that gating takes effect one cycle late.
  // When the gate is closed the prescaler holds its count and does not clear.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (!tr || c_t || mode_chg) begin
      presc_d = '0;
    end else if (run_q) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_en_d = 1'b0;
    if (c_t) begin
      cnt_en_d = fall & run_q & ~mode_chg;
    end else begin
      cnt_en_d = tick;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cin_sync_q  <= '0;
      intx_sync_q <= '0;
      cin_d_q     <= 1'b0;
      c_t_q       <= 1'b0;
      presc_q     <= '0;
      run_q       <= 1'b0;
      cnt_en_q    <= 1'b0;
    end else begin
      cin_sync_q  <= cin_sync_d;
      intx_sync_q <= intx_sync_d;
      cin_d_q     <= cin_d_d;
      c_t_q       <= c_t_d;
      presc_q     <= presc_d;
      run_q       <= run_d;
      cnt_en_q    <= cnt_en_d;
    end
  end

  assign cnt_en = cnt_en_q;
  assign run    = run_q;

  a_no_back_to_back: assert property (@(posedge clk) disable iff (reset)
    cnt_en_q |=> !cnt_en_q);

  a_presc_range: assert property (@(posedge clk) disable iff (reset)
    presc_q <= PRESC_MAX);

endmodule

// File: tb/tb_timer_tick_gen.sv
// Randomized scoreboard bench for timer_tick_gen. The expected strobe edges come from a delay-line
// reference model, and a separate monitor matches them against the strobes the DUT produces.
module tb_timer_tick_gen;

  localparam int unsigned P  = 12;
  localparam int unsigned S  = 2;
  localparam int          NE = 6000;

  logic clk = 1'b0;
  logic reset, gate, intx, tr, cin, c_t;
  logic cnt_en, run;

  always #5 clk = ~clk;

  timer_tick_gen #(.PRESCALE(P), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .gate(gate), .intx(intx), .tr(tr),
    .cin(cin), .c_t(c_t), .cnt_en(cnt_en), .run(run)
  );

  // Input history indexed by the rising edge that samples it. Index 0 is the power-on state.
  logic rst_a [NE];
  logic tr_a  [NE];
  logic gate_a[NE];
  logic intx_a[NE];
  logic cin_a [NE];
  logic ct_a  [NE];
  logic run_m [NE];
  int   lr    [NE];

  int e       = 1;
  int elapsed = 0;
  int exp_q[$];
  int checks  = 0;
  int passes  = 0;
  int pulses  = 0;
  int n       = 0;

  // This returns the output of the last synchroniser stage after edge k. It is the pin value
  // sampled S-1 edges earlier, or 0 if a reset edge occurred since that sample.
  function automatic logic cin_s_at(input int k);
    int idx;
    idx = k - int'(S) + 1;
    if (idx <= lr[k]) return 1'b0;
    return cin_a[idx];
  endfunction

  function automatic logic intx_s_at(input int k);
    int idx;
    idx = k - int'(S) + 1;
    if (idx <= lr[k]) return 1'b0;
    return intx_a[idx];
  endfunction

  function automatic logic cin_d_at(input int k);
    if (k == 0 || lr[k] == k) return 1'b0;
    return cin_s_at(k - 1);
  endfunction

  function automatic logic ct_seen_at(input int k);
    if (lr[k] == k) return 1'b0;
    return ct_a[k];
  endfunction

  task automatic chk(input string name, input logic got, input logic want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s got=%b want=%b", name, got, want);
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s got=%0d want=%0d", name, got, want);
  endtask

  // This drives the inputs for edge e, predicts the response of the DUT at that edge,
  // and then waits until the next falling edge of the clock.
  task automatic step(input logic r, input logic t, input logic g, input logic ix,
                      input logic ci, input logic ct);
    logic fall, chg, en;
    if (e >= NE) begin
      $display("FAIL history_overflow got=%0d want<%0d", e, NE);
      $fatal(1, "history overflow");
    end
    reset = r; tr = t; gate = g; intx = ix; cin = ci; c_t = ct;
    rst_a[e] = r; tr_a[e] = t; gate_a[e] = g; intx_a[e] = ix; cin_a[e] = ci; ct_a[e] = ct;
    lr[e] = r ? e : lr[e-1];
    en = 1'b0;
    if (r) begin
      run_m[e] = 1'b0;
      elapsed  = 0;
    end else begin
      fall = cin_d_at(e - 1) & ~cin_s_at(e - 1);
      chg  = (ct != ct_seen_at(e - 1));
      if (!t || ct || chg) begin
        en      = ct && !chg && fall && run_m[e-1];
        elapsed = 0;
      end else if (run_m[e-1]) begin
        elapsed++;
        en = (elapsed % int'(P) == 0);
      end
      run_m[e] = t & (~g | intx_s_at(e - 1));
    end
    if (en) exp_q.push_back(e);
    @(negedge clk);
    e++;
  endtask

  // Monitor: runs 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (cnt_en === 1'b1) begin
        pulses++;
        checks++;
        if (exp_q.size() != 0 && exp_q[0] == n) begin
          passes++;
          void'(exp_q.pop_front());
        end else begin
          $display("FAIL cnt_en_spurious edge=%0d got=1 want=0", n);
        end
      end
      while (exp_q.size() != 0 && exp_q[0] <= n) begin
        checks++;
        $display("FAIL cnt_en_missing edge=%0d got=%b want=1", n, cnt_en);
        void'(exp_q.pop_front());
      end
      checks++;
      if (run === run_m[n]) passes++;
      else $display("FAIL run edge=%0d got=%b want=%b", n, run, run_m[n]);
    end
  end

  initial begin
    int p0;
    int guard;
    logic rr, rt, rg, ri, rc, rct;
    int hold;

    rst_a[0] = 1'b1; tr_a[0] = 1'b0; gate_a[0] = 1'b0; intx_a[0] = 1'b0;
    cin_a[0] = 1'b0; ct_a[0] = 1'b0; run_m[0] = 1'b0; lr[0] = 0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reset_cnt_en", cnt_en, 1'b0);
    chk("reset_run", run, 1'b0);

    // Timer mode: 121 edges starting at the rise of run contain exactly 10 ticks.
    p0 = pulses;
    repeat (121) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_int("timer_pulses", pulses - p0, 10);

    // Counter mode: 10 pulses on cin, each 6 cycles high and 6 cycles low.
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    p0 = pulses;
    repeat (10) begin
      repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_int("counter_pulses", pulses - p0, 10);

    // Gating: while intx is low, run stays 0 and no ticks occur. Then intx is opened.
    p0 = pulses;
    repeat (50) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_int("gated_pulses", pulses - p0, 0);
    chk("gated_run", run, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Gated hold: close the gate at count 7, keep it closed for 20 cycles, then reopen it.
    guard = 0;
    while (elapsed % int'(P) != 7 && guard < 40) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      guard++;
    end
    chk_int("reach_count7", elapsed % int'(P), 7);
    repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Boundary conditions: toggle c_t at the last count, then drop tr at the last count.
    guard = 0;
    while (elapsed % int'(P) != int'(P) - 1 && guard < 40) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    chk_int("reach_max_ct", elapsed % int'(P), int'(P) - 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (elapsed % int'(P) != int'(P) - 1 && guard < 40) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    chk_int("reach_max_tr", elapsed % int'(P), int'(P) - 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a count while cin is held low.
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midreset_cnt_en", cnt_en, 1'b0);
    chk("midreset_run", run, 1'b0);
    repeat (30) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random phase: every input changes at random, including short glitches on cin and occasional resets.
    rt = 1'b1; rg = 1'b0; ri = 1'b1; rc = 1'b1; rct = 1'b0; hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        rc   = ~rc;
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 39) == 0) rt = ~rt;
      if ($urandom_range(0, 29) == 0) rg = ~rg;
      if ($urandom_range(0, 9) == 0) ri = ~ri;
      if ($urandom_range(0, 59) == 0) rct = ~rct;
      rr = ($urandom_range(0, 299) == 0);
      step(rr, rt, rg, ri, rc, rct);
    end

    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_int("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
